siphash_msg_ctrl: RTL and testbench

Message sequencer for the SipHash core. It accepts a little-endian 64-bit word stream with a valid/ready handshake. It drives the core's initalize/compress/finalize commands and builds the SipHash final block (tail bytes plus length byte). It returns the digest, reduced to 64 bits in short mode. It sits between the bus wrapper and siphash_core, and replaces software sequencing of the core.

---
 rtl/siphash_msg_ctrl_pkg.sv | 34 +++
 rtl/siphash_tail_pad.sv | 24 ++
 rtl/siphash_msg_ctrl.sv | 159 +++++++++++++++
 tb/tb_siphash_msg_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/siphash_msg_ctrl_pkg.sv
// Shared types and constants for the SipHash message sequencer and its helpers.
package siphash_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_GET,
        S_COMP,
        S_CWAIT,
        S_PAD,
        S_FIN,
        S_FWAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_INIT,
        CMD_COMP,
        CMD_FIN
    } cmd_t;

    // Initial state words "somepseudorandomlygeneratedbytes", XORed with the key by the core.
    localparam logic [63:0] SIP_IV0 = 64'h736f6d6570736575;
    localparam logic [63:0] SIP_IV1 = 64'h646f72616e646f6d;
    localparam logic [63:0] SIP_IV2 = 64'h6c7967656e657261;
    localparam logic [63:0] SIP_IV3 = 64'h7465646279746573;

    // Core output is {v0^v1, v2^v3}; the 64-bit digest is v0^v1^v2^v3.
    function automatic logic [63:0] fold64(input logic [127:0] w);
        return w[127:64] ^ w[63:0];
    endfunction

endpackage

// File: rtl/siphash_tail_pad.sv
// Builds a SipHash compression block from a message word: keeps the first
// msg_bytes bytes and, for a partial word, puts the length byte in byte 7.
module siphash_tail_pad (
    input  logic [63:0] msg_data,
    input  logic [3:0]  msg_bytes,
    input  logic [7:0]  len8,
    output logic [63:0] block
);

    always_comb begin
        block = '0;
        if (msg_bytes >= 4'd8) begin
            block = msg_data;
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (4'(i) < msg_bytes) begin
                    block[8*i +: 8] = msg_data[8*i +: 8];
                end
            end
            block[63:56] = len8;
        end
    end

endmodule

// File: rtl/siphash_msg_ctrl.sv
// SipHash message sequencer: takes a little-endian word stream, drives the
// core's initialize/compress/finalize commands and returns the digest.
module siphash_msg_ctrl
    import siphash_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         long,
    input  logic [3:0]   compression_rounds,
    input  logic [3:0]   final_rounds,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [63:0]  msg_data,
    input  logic [3:0]   msg_bytes,
    input  logic         msg_last,
    output logic         core_initalize,
    output logic         core_compress,
    output logic         core_finalize,
    output logic         core_long,
    output logic [127:0] core_key,
    output logic [3:0]   core_c_rounds,
    output logic [3:0]   core_d_rounds,
    output logic [63:0]  core_mi,
    input  logic         core_ready,
    input  logic [127:0] core_word,
    input  logic         core_word_valid,
    output logic [127:0] digest,
    output logic         digest_valid,
    output logic         busy,
    output logic         error
);

    state_t             state;
    state_t             after_comp;
    cmd_t               cmd_q;
    logic [LEN_W-1:0]   byte_cnt;
    logic [LEN_W-1:0]   cnt_next;
    logic [63:0]        pad_block;
    logic               bad_word;

    assign cnt_next = byte_cnt + LEN_W'(msg_bytes);
    assign bad_word = (msg_bytes > 4'd8) || ((msg_bytes != 4'd8) && !msg_last);

    assign core_initalize = (cmd_q == CMD_INIT);
    assign core_compress  = (cmd_q == CMD_COMP);
    assign core_finalize  = (cmd_q == CMD_FIN);

    siphash_tail_pad u_tail_pad (
        .msg_data  (msg_data),
        .msg_bytes (msg_bytes),
        .len8      (cnt_next[7:0]),
        .block     (pad_block)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            after_comp    <= S_IDLE;
            cmd_q         <= CMD_NONE;
            byte_cnt      <= '0;
            msg_ready     <= 1'b0;
            core_long     <= 1'b0;
            core_key      <= '0;
            core_c_rounds <= '0;
            core_d_rounds <= '0;
            core_mi       <= '0;
            digest        <= '0;
            digest_valid  <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
        end else begin
            cmd_q <= CMD_NONE;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        core_key      <= key;
                        core_long     <= long;
                        core_c_rounds <= compression_rounds;
                        core_d_rounds <= final_rounds;
                        byte_cnt      <= '0;
                        digest_valid  <= 1'b0;
                        error         <= 1'b0;
                        busy          <= 1'b1;
                        state         <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (core_ready) begin
                        cmd_q     <= CMD_INIT;
                        msg_ready <= 1'b1;
                        state     <= S_GET;
                    end
                end
                S_GET: begin
                    if (msg_valid && msg_ready) begin
                        msg_ready <= 1'b0;
                        if (bad_word) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            // Full words pass through the pad builder unchanged.
                            byte_cnt <= cnt_next;
                            core_mi  <= pad_block;
                            state    <= S_COMP;
                            if (!msg_last) begin
                                after_comp <= S_GET;
                            end else if (msg_bytes == 4'd8) begin
                                after_comp <= S_PAD;
                            end else begin
                                after_comp <= S_FIN;
                            end
                        end
                    end
                end
                S_PAD: begin
                    core_mi    <= {byte_cnt[7:0], 56'h0};
                    after_comp <= S_FIN;
                    state      <= S_COMP;
                end
                S_COMP: begin
                    if (core_ready) begin
                        cmd_q <= CMD_COMP;
                        state <= S_CWAIT;
                    end
                end
                S_CWAIT: begin
                    // The core still reports ready during the command cycle itself.
                    if (core_ready && (cmd_q == CMD_NONE)) begin
                        state <= after_comp;
                        if (after_comp == S_GET) begin
                            msg_ready <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    if (core_ready) begin
                        cmd_q <= CMD_FIN;
                        state <= S_FWAIT;
                    end
                end
                S_FWAIT: begin
                    if (core_word_valid && core_ready && (cmd_q == CMD_NONE)) begin
                        digest       <= core_long ? core_word : {64'h0, fold64(core_word)};
                        digest_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_siphash_msg_ctrl.sv
// Directed bench for siphash_msg_ctrl with a behavioural SipHash core model.
module tb_siphash_msg_ctrl;
    import siphash_pkg::*;

    localparam logic [127:0] REF_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [127:0] key;
    logic         long;
    logic [3:0]   compression_rounds;
    logic [3:0]   final_rounds;
    logic         msg_valid;
    logic         msg_ready;
    logic [63:0]  msg_data;
    logic [3:0]   msg_bytes;
    logic         msg_last;
    logic         core_initalize;
    logic         core_compress;
    logic         core_finalize;
    logic         core_long;
    logic [127:0] core_key;
    logic [3:0]   core_c_rounds;
    logic [3:0]   core_d_rounds;
    logic [63:0]  core_mi;
    logic         core_ready;
    logic [127:0] core_word;
    logic         core_word_valid;
    logic [127:0] digest;
    logic         digest_valid;
    logic         busy;
    logic         error;

    always #5 clk = ~clk;

    siphash_msg_ctrl #(.LEN_W(8)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .key                (key),
        .long               (long),
        .compression_rounds (compression_rounds),
        .final_rounds       (final_rounds),
        .msg_valid          (msg_valid),
        .msg_ready          (msg_ready),
        .msg_data           (msg_data),
        .msg_bytes          (msg_bytes),
        .msg_last           (msg_last),
        .core_initalize     (core_initalize),
        .core_compress      (core_compress),
        .core_finalize      (core_finalize),
        .core_long          (core_long),
        .core_key           (core_key),
        .core_c_rounds      (core_c_rounds),
        .core_d_rounds      (core_d_rounds),
        .core_mi            (core_mi),
        .core_ready         (core_ready),
        .core_word          (core_word),
        .core_word_valid    (core_word_valid),
        .digest             (digest),
        .digest_valid       (digest_valid),
        .busy               (busy),
        .error              (error)
    );

    int vec_cnt = 0;
    int miss_cnt = 0;
    int comp_cnt = 0;
    int fin_cnt = 0;
    int stall_max = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- SipHash reference functions ----------------
    function automatic logic [63:0] rotl(input logic [63:0] x, input int b);
        return (x << b) | (x >> (64 - b));
    endfunction

    function automatic logic [255:0] sip_rounds(input logic [255:0] s, input int n);
        logic [63:0] v0, v1, v2, v3;
        {v0, v1, v2, v3} = s;
        for (int r = 0; r < n; r++) begin
            v0 = v0 + v1; v1 = rotl(v1, 13); v1 = v1 ^ v0; v0 = rotl(v0, 32);
            v2 = v2 + v3; v3 = rotl(v3, 16); v3 = v3 ^ v2;
            v0 = v0 + v3; v3 = rotl(v3, 21); v3 = v3 ^ v0;
            v2 = v2 + v1; v1 = rotl(v1, 17); v1 = v1 ^ v2; v2 = rotl(v2, 32);
        end
        return {v0, v1, v2, v3};
    endfunction

    function automatic logic [255:0] init_fn(input logic [127:0] k, input logic lng);
        logic [63:0] k0, k1;
        k0 = k[63:0];
        k1 = k[127:64];
        return {k0 ^ 64'h736f6d6570736575, k1 ^ 64'h646f72616e646f6d ^ (lng ? 64'hee : 64'h0),
                k0 ^ 64'h6c7967656e657261, k1 ^ 64'h7465646279746573};
    endfunction

    function automatic logic [255:0] compress_fn(input logic [255:0] s, input logic [63:0] m, input int n);
        logic [255:0] t;
        t = s;
        t[63:0] = t[63:0] ^ m;
        t = sip_rounds(t, n);
        t[255:192] = t[255:192] ^ m;
        return t;
    endfunction

    function automatic logic [255:0] final_fn(input logic [255:0] s, input logic lng, input int n);
        logic [255:0] t;
        t = s;
        t[127:64] = t[127:64] ^ (lng ? 64'hee : 64'hff);
        return sip_rounds(t, n);
    endfunction

    function automatic logic [63:0] msg_word(input int w);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = 8'(8*w + b);
        return r;
    endfunction

    // Block k of the SipHash-padded message of bytes 00 01 02 ... of length len.
    function automatic logic [63:0] ref_block(input int len, input int k);
        logic [63:0] r;
        if (k < len / 8) return msg_word(k);
        r = '0;
        for (int b = 0; b < len % 8; b++) r[8*b +: 8] = 8'(8*k + b);
        r[63:56] = 8'(len);
        return r;
    endfunction

    function automatic logic [127:0] ref_word(input int len, input logic lng);
        logic [255:0] s;
        s = init_fn(REF_KEY, lng);
        for (int k = 0; k <= len / 8; k++) s = compress_fn(s, ref_block(len, k), 2);
        s = final_fn(s, lng, 4);
        return {s[255:192] ^ s[191:128], s[127:64] ^ s[63:0]};
    endfunction

    // ---------------- behavioural core ----------------
    logic [255:0] cs;
    int           core_wait;
    logic         core_is_fin;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready      <= 1'b1;
            core_word_valid <= 1'b0;
            core_word       <= '0;
            cs              <= '0;
            core_wait       <= 0;
            core_is_fin     <= 1'b0;
        end else if (core_initalize) begin
            cs              <= init_fn(core_key, core_long);
            core_ready      <= 1'b0;
            core_word_valid <= 1'b0;
            core_is_fin     <= 1'b0;
            core_wait       <= 1 + int'($urandom_range(0, stall_max));
        end else if (core_compress) begin
            cs         <= compress_fn(cs, core_mi, int'(core_c_rounds));
            core_ready <= 1'b0;
            core_wait  <= int'(core_c_rounds) + 2 + int'($urandom_range(0, stall_max));
        end else if (core_finalize) begin
            cs          <= final_fn(cs, core_long, int'(core_d_rounds));
            core_ready  <= 1'b0;
            core_is_fin <= 1'b1;
            core_wait   <= int'(core_d_rounds) + 2 + int'($urandom_range(0, stall_max));
        end else if (core_wait > 1) begin
            core_wait <= core_wait - 1;
        end else if (core_wait == 1) begin
            core_wait  <= 0;
            core_ready <= 1'b1;
            if (core_is_fin) begin
                core_word_valid <= 1'b1;
                core_word       <= {cs[255:192] ^ cs[191:128], cs[127:64] ^ cs[63:0]};
            end
        end
    end

    // ---------------- scoreboard on compress blocks ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (core_compress) begin
                comp_cnt++;
                if (exp_q.size() == 0) begin
                    check("mi_unexpected", 128'(exp_q.size()), 128'd1);
                end else begin
                    check("core_mi", 128'(core_mi), 128'(exp_q.pop_front()));
                end
            end
            if (core_finalize) fin_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [127:0] k, input logic lng);
        @(negedge clk);
        start = 1'b1;
        key = k;
        long = lng;
        compression_rounds = 4'd2;
        final_rounds = 4'd4;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] d, input logic [3:0] n, input logic l, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        msg_data = d;
        msg_bytes = n;
        msg_last = l;
        msg_valid = 1'b1;
        while (!msg_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("accept_timeout", 128'(t), 128'd0);
        @(negedge clk);
        msg_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!digest_valid && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done"}, 128'(digest_valid), 128'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 128'({msg_ready, core_initalize, core_compress, core_finalize,
                                    core_long, core_c_rounds, core_d_rounds, digest_valid, busy, error}), 128'd0);
        check({tag, "_key"}, core_key, 128'd0);
        check({tag, "_mi"}, 128'(core_mi), 128'd0);
        check({tag, "_digest"}, digest, 128'd0);
    endtask

    task automatic run_msg(input int len, input int gap_max, input logic lng, input logic poke);
        int nw;
        int n;
        logic [127:0] w;
        for (int k = 0; k <= len / 8; k++) exp_q.push_back(ref_block(len, k));
        do_start(REF_KEY, lng);
        nw = (len == 0) ? 1 : (len + 7) / 8;
        for (int i = 0; i < nw; i++) begin
            n = (i < nw - 1) ? 8 : len - 8 * i;
            send_word(msg_word(i), 4'(n), i == nw - 1, int'($urandom_range(0, gap_max)));
            if (poke && i == 0) begin
                start = 1'b1;
                key = ~REF_KEY;
                @(negedge clk);
                start = 1'b0;
                key = REF_KEY;
            end
        end
        wait_done($sformatf("len%0d", len));
        w = ref_word(len, lng);
        check($sformatf("digest_len%0d", len), digest, lng ? w : {64'h0, w[127:64] ^ w[63:0]});
        check($sformatf("mi_left_len%0d", len), 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cc, fc, t;
        int lens[12] = '{63, 64, 65, 127, 128, 247, 248, 255, 256, 257, 263, 300};
        reset_n = 1'b0;
        start = 1'b0;
        key = '0;
        long = 1'b0;
        compression_rounds = '0;
        final_rounds = '0;
        msg_valid = 1'b0;
        msg_data = '0;
        msg_bytes = '0;
        msg_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_state", 128'(dut.state), 128'(S_IDLE));
        reset_n = 1'b1;

        // Empty message
        exp_q.push_back(64'h0000000000000000);
        do_start(REF_KEY, 1'b0);
        check("busy_after_start", 128'(busy), 128'd1);
        send_word(64'h0, 4'd0, 1'b1, 0);
        check("core_key", core_key, REF_KEY);
        check("core_rounds", 128'({core_c_rounds, core_d_rounds, core_long}), 128'h048);
        wait_done("empty");
        check("digest_empty", digest, 128'h726fdb47dd0e0e31);

        // One full last word: length goes in a separate block
        exp_q.push_back(64'h0706050403020100);
        exp_q.push_back(64'h0800000000000000);
        do_start(REF_KEY, 1'b0);
        send_word(64'h0706050403020100, 4'd8, 1'b1, 0);
        wait_done("len8");
        check("digest_len8", digest, 128'h93f5f5799a932462);

        // 8 + 7 bytes; junk in byte 7 of the tail must be replaced by the length
        exp_q.push_back(64'h0706050403020100);
        exp_q.push_back(64'h0f0e0d0c0b0a0908);
        do_start(REF_KEY, 1'b0);
        send_word(64'h0706050403020100, 4'd8, 1'b0, 0);
        send_word(64'hff0e0d0c0b0a0908, 4'd7, 1'b1, 2);
        wait_done("len15");
        check("digest_len15", digest, 128'ha129ca6149be45e5);
        repeat (5) @(negedge clk);
        check("digest_hold", {digest[126:0], digest_valid}, {127'h0000000000000000a129ca6149be45e5, 1'b1});

        // Short non-last word is a protocol error
        cc = comp_cnt;
        fc = fin_cnt;
        do_start(REF_KEY, 1'b0);
        send_word(64'h1122334455667788, 4'd5, 1'b0, 0);
        check("err_flag", 128'(error), 128'd1);
        check("err_state", 128'(dut.state), 128'(S_IDLE));
        check("err_valid_busy", 128'({digest_valid, busy, msg_ready}), 128'd0);
        repeat (10) @(negedge clk);
        check("err_no_cmds", 128'({comp_cnt - cc, fin_cnt - fc}), 128'd0);
        run_msg(15, 1, 1'b0, 1'b0);
        check("err_cleared", 128'(error), 128'd0);

        // msg_bytes above 8 is an error even on the last word
        do_start(REF_KEY, 1'b0);
        send_word(64'h0, 4'd9, 1'b1, 0);
        check("err_bytes9", 128'({error, digest_valid}), 128'b10);

        // Reset while waiting on a compress
        stall_max = 2;
        exp_q.push_back(msg_word(0));
        do_start(REF_KEY, 1'b0);
        send_word(msg_word(0), 4'd8, 1'b0, 0);
        t = 0;
        while (dut.state != S_CWAIT && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reach_cwait", 128'(dut.state), 128'(S_CWAIT));
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        check("abort_state", 128'(dut.state), 128'(S_IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();

        // Long mode returns the full core word
        run_msg(15, 2, 1'b1, 1'b0);

        // Length sweep with gaps, stalls and ignored start pulses
        for (int len = 0; len <= 20; len++) run_msg(len, 3, 1'b0, len % 3 == 0);
        foreach (lens[i]) run_msg(lens[i], 3, 1'b0, i % 2 == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
